// File: rtl/mfp_ahb_timer.sv
// mfp_ahb_timer
// AHB-Lite responder holding a 32-bit prescaled up-counter with compare,
// sticky match flag and a registered level interrupt.
//
// Ports:
//   HCLK       - the single clock, all logic on its rising edge
//   SI_Reset   - synchronous, active-high reset
//   HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY - AHB-Lite address phase
//   HWDATA     - write data (data phase)
//   HREADYOUT  - low only while a read is waiting
//   HRDATA     - read data, zero outside the final read data-phase cycle
//   HRESP      - always OKAY
//   IRQ        - registered MATCH & IRQ_EN
//
// Register map (HADDR[3:2]):
//   0 COUNT   (RW)
//   1 COMPARE (RW)
//   2 CONTROL (RW) bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN, bits[15:8] PRESCALE
//   3 STATUS  bit0 MATCH, write 1 to clear
//
// state | meaning
// IDLE  | no data phase in progress
// WDATA | write data phase, register takes HWDATA at the closing edge
// RWAIT | read wait states, HREADYOUT low
// RDATA | final read data-phase cycle, HRDATA driven
module mfp_ahb_timer #(
    parameter int READ_WAIT = 1
) (
    input  logic        HCLK,
    input  logic        SI_Reset,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    output logic        HRESP,
    output logic        IRQ
);

    typedef enum logic [1:0] {IDLE, WDATA, RWAIT, RDATA} state_t;

    state_t      state;
    logic [1:0]  addr_q;
    logic        word_q;
    logic [1:0]  wait_cnt;

    logic [31:0] count;
    logic [31:0] compare;
    logic        en;
    logic        auto_reload;
    logic        irq_en;
    logic [7:0]  prescale;
    logic [7:0]  pre;
    logic        match;
    logic        irq;

    logic        accept;
    logic        wr_word;
    logic        tick;
    logic        hit;
    logic        unused_bits;

    assign accept  = HSEL & HTRANS[1] & HREADY;
    assign wr_word = (state == WDATA) & word_q;
    assign tick    = en & (pre == prescale);
    // Compare uses the pre-edge COMPARE, so a COMPARE write only matters
    // from the following cycle.
    assign hit     = tick & (count == compare);

    assign unused_bits = ^{HADDR[31:4], HADDR[1:0], HTRANS[0]};

    always_ff @(posedge HCLK) begin
        if (SI_Reset) begin
            state    <= IDLE;
            addr_q   <= 2'd0;
            word_q   <= 1'b0;
            wait_cnt <= 2'd0;
        end else begin
            case (state)
                RWAIT: begin
                    if (wait_cnt == 2'd1) begin
                        state <= RDATA;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                default: begin
                    // IDLE, WDATA and RDATA all have HREADYOUT=1, so a new
                    // address phase can be taken back-to-back.
                    if (accept) begin
                        addr_q <= HADDR[3:2];
                        word_q <= (HSIZE == 3'b010);
                        if (HWRITE) begin
                            state <= WDATA;
                        end else if (READ_WAIT == 0) begin
                            state <= RDATA;
                        end else begin
                            state    <= RWAIT;
                            wait_cnt <= 2'(READ_WAIT);
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge HCLK) begin
        if (SI_Reset) begin
            count       <= 32'd0;
            compare     <= 32'd0;
            en          <= 1'b0;
            auto_reload <= 1'b0;
            irq_en      <= 1'b0;
            prescale    <= 8'd0;
            pre         <= 8'd0;
            match       <= 1'b0;
            irq         <= 1'b0;
        end else begin
            irq <= match & irq_en;

            if (wr_word && addr_q == 2'd2) begin
                pre <= 8'd0;
            end else if (!en || tick) begin
                pre <= 8'd0;
            end else begin
                pre <= pre + 8'd1;
            end

            // A COUNT write overrides the tick update.
            if (wr_word && addr_q == 2'd0) begin
                count <= HWDATA;
            end else if (tick) begin
                count <= (hit && auto_reload) ? 32'd0 : count + 32'd1;
            end

            // Setting MATCH wins over a simultaneous write-1-to-clear.
            if (hit) begin
                match <= 1'b1;
            end else if (wr_word && addr_q == 2'd3 && HWDATA[0]) begin
                match <= 1'b0;
            end

            if (wr_word && addr_q == 2'd1) begin
                compare <= HWDATA;
            end

            if (wr_word && addr_q == 2'd2) begin
                en          <= HWDATA[0];
                auto_reload <= HWDATA[1];
                irq_en      <= HWDATA[2];
                prescale    <= HWDATA[15:8];
            end
        end
    end

    always_comb begin
        HRDATA = 32'd0;
        if (state == RDATA) begin
            case (addr_q)
                2'd0: HRDATA = count;
                2'd1: HRDATA = compare;
                2'd2: HRDATA = {16'd0, prescale, 5'd0, irq_en, auto_reload, en};
                default: HRDATA = {31'd0, match};
            endcase
        end
    end

    assign HREADYOUT = (state != RWAIT);
    assign HRESP     = 1'b0;
    assign IRQ       = irq;

endmodule

// File: tb/tb_mfp_ahb_timer.sv
module tb_mfp_ahb_timer;

    parameter int RW = 1;

    logic        HCLK = 1'b0;
    logic        SI_Reset;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic        HRESP;
    logic        IRQ;

    mfp_ahb_timer #(.READ_WAIT(RW)) dut (
        .HCLK(HCLK), .SI_Reset(SI_Reset), .HSEL(HSEL), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
        .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRDATA(HRDATA),
        .HRESP(HRESP), .IRQ(IRQ)
    );

    always #5 HCLK = ~HCLK;

    int cyc = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    bit mon_on = 0;

    // Expected reads: data-phase window in bench cycles plus register index.
    typedef struct {
        int         first;
        int         due;
        logic [1:0] addr;
    } rd_t;
    rd_t rq[$];

    // Write occurring in the current data-phase cycle, as seen by the model.
    bit         mw_valid = 0;
    logic [1:0] mw_addr = 0;
    bit         mw_word = 0;
    logic [31:0] mw_data = 0;

    bit         wpend = 0;
    logic [1:0] wp_addr = 0;
    bit         wp_word = 0;
    logic [31:0] wp_data = 0;

    // Reference model: timer registers updated once per clock.
    logic [31:0] m_cnt = 0, m_cmp = 0;
    bit          m_en = 0, m_ar = 0, m_ie = 0, m_match = 0, m_irq = 0;
    logic [7:0]  m_ps = 0, m_pre = 0;

    always @(posedge HCLK) begin
        bit          tick, hit, n_match, n_en, n_ar, n_ie;
        logic [31:0] n_cnt, n_cmp;
        logic [7:0]  n_ps, n_pre;
        if (SI_Reset) begin
            m_cnt = 0; m_cmp = 0; m_en = 0; m_ar = 0; m_ie = 0;
            m_match = 0; m_irq = 0; m_ps = 0; m_pre = 0;
        end else begin
            tick    = m_en && (m_pre == m_ps);
            hit     = tick && (m_cnt == m_cmp);
            n_cnt   = m_cnt;
            if (tick) n_cnt = (hit && m_ar) ? 32'd0 : m_cnt + 32'd1;
            n_pre   = (!m_en || tick) ? 8'd0 : m_pre + 8'd1;
            n_match = hit ? 1'b1 : m_match;
            n_cmp = m_cmp; n_en = m_en; n_ar = m_ar; n_ie = m_ie; n_ps = m_ps;
            if (mw_valid && mw_word) begin
                case (mw_addr)
                    2'd0: n_cnt = mw_data;
                    2'd1: n_cmp = mw_data;
                    2'd2: begin
                        n_en = mw_data[0]; n_ar = mw_data[1]; n_ie = mw_data[2];
                        n_ps = mw_data[15:8]; n_pre = 8'd0;
                    end
                    default: if (mw_data[0] && !hit) n_match = 1'b0;
                endcase
            end
            m_irq = m_match && m_ie;
            m_cnt = n_cnt; m_cmp = n_cmp; m_en = n_en; m_ar = n_ar; m_ie = n_ie;
            m_ps = n_ps; m_pre = n_pre; m_match = n_match;
        end
    end

    function automatic logic [31:0] model_read(input logic [1:0] a);
        case (a)
            2'd0: return m_cnt;
            2'd1: return m_cmp;
            2'd2: return {16'd0, m_ps, 5'd0, m_ie, m_ar, m_en};
            default: return {31'd0, m_match};
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Monitor: every cycle compares the DUT outputs; a read record is popped
    // when its final data-phase cycle is presented.
    always @(negedge HCLK) begin
        bit          exp_rdy, is_rd;
        logic [31:0] exp_data;
        if (mon_on) begin
            exp_rdy  = 1'b1;
            exp_data = 32'd0;
            is_rd    = 1'b0;
            if (rq.size() > 0 && cyc >= rq[0].first) begin
                if (cyc < rq[0].due) begin
                    exp_rdy = 1'b0;
                end else begin
                    is_rd    = 1'b1;
                    exp_data = model_read(rq[0].addr);
                end
            end
            chk("hreadyout", {31'd0, HREADYOUT}, {31'd0, exp_rdy});
            chk(is_rd ? "read_data" : "hrdata_idle", HRDATA, exp_data);
            chk("hresp", {31'd0, HRESP}, 32'd0);
            chk("irq", {31'd0, IRQ}, {31'd0, m_irq});
            if (is_rd) void'(rq.pop_front());
        end
    end

    // One bus cycle slot: presents an address phase (or idle) and carries the
    // previous write's data phase. Reads hold the bus for their wait states.
    task automatic present(input bit act, input bit wr, input logic [1:0] a,
                           input logic [2:0] sz, input logic [31:0] d, input bit rst_mid);
        logic [31:0] r;
        @(negedge HCLK);
        SI_Reset = 1'b0;
        r        = $urandom;
        mw_valid = wpend; mw_addr = wp_addr; mw_word = wp_word; mw_data = wp_data;
        HWDATA   = wpend ? wp_data : $urandom;
        wpend    = 1'b0;
        HREADY   = 1'b1;
        HADDR    = {r[31:4], a, r[1:0]};
        if (act) begin
            HSEL   = 1'b1;
            HTRANS = r[4] ? 2'b10 : 2'b11;
            HWRITE = wr;
            HSIZE  = sz;
            if (wr) begin
                wpend = 1'b1; wp_addr = a; wp_word = (sz == 3'b010); wp_data = d;
            end else begin
                rq.push_back('{first: cyc + 1, due: cyc + 1 + RW, addr: a});
                for (int i = 0; i < RW; i++) begin
                    @(negedge HCLK);
                    mw_valid = 1'b0;
                    HREADY   = 1'b0;
                    HWDATA   = $urandom;
                    if (rst_mid) begin
                        SI_Reset = 1'b1;
                        break;
                    end
                end
            end
        end else begin
            HSEL   = r[5];
            HTRANS = r[5] ? {1'b0, r[6]} : 2'b10;
            HWRITE = r[7];
            HSIZE  = 3'b010;
        end
    endtask

    task automatic wr32(input logic [1:0] a, input logic [31:0] d);
        present(1, 1, a, 3'b010, d, 0);
    endtask

    task automatic rd(input logic [1:0] a);
        present(1, 0, a, 3'b010, 32'd0, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) present(0, 0, 2'd0, 3'b010, 32'd0, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        SI_Reset = 1'b1; HSEL = 0; HADDR = 0; HTRANS = 0; HWRITE = 0;
        HSIZE = 3'b010; HWDATA = 0; HREADY = 1'b1;
        @(posedge HCLK);
        #1 mon_on = 1;
        @(posedge HCLK);

        // Reset values of all four registers.
        for (int a = 0; a < 4; a++) rd(2'(a));
        idle(2);

        // Auto-reload match with interrupt, then clear.
        wr32(2'd1, 32'd5);
        wr32(2'd2, 32'h0000_0007);
        for (int i = 0; i < 6; i++) rd(2'd0);
        rd(2'd3);
        wr32(2'd3, 32'd1);
        idle(3);
        wr32(2'd2, 32'd0);
        wr32(2'd3, 32'd1);
        idle(2);

        // Prescale 3 and wrap from all-ones without a match.
        wr32(2'd1, 32'h10);
        wr32(2'd0, 32'hFFFF_FFFF);
        wr32(2'd2, 32'h0000_0301);
        for (int i = 0; i < 8; i++) begin
            rd(2'd0);
            idle(1);
        end
        rd(2'd3);

        // COUNT write on a tick edge, and STATUS clear on the match edge.
        wr32(2'd2, 32'h0000_0005);
        wr32(2'd0, 32'h100);
        rd(2'd0);
        wr32(2'd1, 32'h200);
        wr32(2'd0, 32'h200);
        wr32(2'd3, 32'd1);
        rd(2'd3);
        idle(2);

        // Back-to-back write / read / byte write with the timer stopped.
        wr32(2'd2, 32'd0);
        wr32(2'd0, 32'h1234_5678);
        rd(2'd0);
        present(1, 1, 2'd1, 3'b000, 32'hDEAD_BEEF, 0);
        rd(2'd1);
        present(1, 1, 2'd1, 3'b001, 32'h0000_BEEF, 0);
        rd(2'd1);

        // Reset during read wait states.
        wr32(2'd2, 32'h0000_0007);
        wr32(2'd1, 32'd3);
        idle(8);
        if (RW > 0) begin
            present(1, 0, 2'd0, 3'b010, 32'd0, 1);
            @(posedge HCLK);
            #1 rq.delete();
            wpend = 0;
        end
        for (int a = 0; a < 4; a++) rd(2'(a));

        // Randomized traffic.
        repeat (400) begin
            int          k;
            bit          w;
            logic [1:0]  a;
            logic [2:0]  sz;
            logic [31:0] d;
            k  = $urandom_range(0, 9);
            w  = 1'($urandom_range(0, 1));
            a  = 2'($urandom_range(0, 3));
            sz = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 1)) : 3'b010;
            case (a)
                2'd0, 2'd1: d = $urandom_range(0, 40);
                2'd2: d = ($urandom & 32'hFFFF_00FF) | (32'($urandom_range(0, 3)) << 8);
                default: d = $urandom;
            endcase
            if (k < 2) idle(1 + k);
            else present(1, w, a, sz, d, 0);
        end

        idle(RW + 4);
        @(negedge HCLK);
        chk("read_queue_drained", rq.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
